// File: rtl/mem_bus_master_if.sv
// Command/response handshake between a control initiator and mem_bus_master.
// The master modport is the command source; the slave modport is the bus master block.
interface mem_bus_master_if #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8,
    parameter int LWIDTH = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_desc;
    logic [AWIDTH-1:0] req_addr;
    logic [DWIDTH-1:0] req_wdata;
    logic [LWIDTH-1:0] req_len;
    logic              rsp_valid;
    logic [DWIDTH-1:0] rsp_rdata;
    logic              busy;

    modport master (
        output req_valid, req_write, req_desc, req_addr, req_wdata, req_len,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_write, req_desc, req_addr, req_wdata, req_len,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/mem_bus_master.sv
// Burst initiator for a single-port memory with a shared tri-state data bus.
// Writes take one clock per beat; reads take two (address, capture) plus one TURN cycle.
module mem_bus_master #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8,
    parameter int LWIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_bus_master_if.slave   req_if,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [AWIDTH-1:0] mem_addr,
    inout  wire  [DWIDTH-1:0] mem_data
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ADDR,
        RD_CAP,
        TURN
    } state_e;

    state_e            state_q,     state_d;
    logic              mem_wr_q,    mem_wr_d;
    logic              mem_rd_q,    mem_rd_d;
    logic              mem_oe_q,    mem_oe_d;
    logic              desc_q,      desc_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [AWIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DWIDTH-1:0] wdata_q,     wdata_d;
    logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [LWIDTH-1:0] beats_q,     beats_d;

    logic              last_beat;
    logic [AWIDTH-1:0] next_addr;

    // beats_q holds the beats still to go after the current one.
    assign last_beat = (beats_q == '0);
    assign next_addr = desc_q ? (mem_addr_q - AWIDTH'(1)) : (mem_addr_q + AWIDTH'(1));

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch to hold the old value.
        state_d     = state_q;
        mem_wr_d    = mem_wr_q;
        mem_rd_d    = mem_rd_q;
        mem_oe_d    = mem_oe_q;
        desc_d      = desc_q;
        mem_addr_d  = mem_addr_q;
        wdata_d     = wdata_q;
        beats_d     = beats_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_if.req_valid) begin
                    mem_addr_d = req_if.req_addr;
                    wdata_d    = req_if.req_wdata;
                    beats_d    = req_if.req_len;
                    desc_d     = req_if.req_desc;
                    if (req_if.req_write) begin
                        state_d  = WRITE;
                        mem_wr_d = 1'b1;
                        mem_oe_d = 1'b1;
                    end else begin
                        state_d  = RD_ADDR;
                        mem_rd_d = 1'b1;
                    end
                end
            end

            WRITE: begin
                if (last_beat) begin
                    state_d  = IDLE;
                    mem_wr_d = 1'b0;
                    mem_oe_d = 1'b0;
                end else begin
                    beats_d    = beats_q - LWIDTH'(1);
                    mem_addr_d = next_addr;
                    wdata_d    = wdata_q + DWIDTH'(1);
                end
            end

            RD_ADDR: begin
                state_d = RD_CAP;
            end

            RD_CAP: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = mem_data;
                if (last_beat) begin
                    // Memory still drives the bus this cycle; TURN gives it a clock to let go.
                    state_d  = TURN;
                    mem_rd_d = 1'b0;
                end else begin
                    state_d    = RD_ADDR;
                    beats_d    = beats_q - LWIDTH'(1);
                    mem_addr_d = next_addr;
                end
            end

            TURN: begin
                state_d = IDLE;
            end

            default: begin
                state_d  = IDLE;
                mem_wr_d = 1'b0;
                mem_rd_d = 1'b0;
                mem_oe_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_oe_q    <= 1'b0;
            desc_q      <= 1'b0;
            mem_addr_q  <= '0;
            wdata_q     <= '0;
            beats_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_wr_q    <= mem_wr_d;
            mem_rd_q    <= mem_rd_d;
            mem_oe_q    <= mem_oe_d;
            desc_q      <= desc_d;
            mem_addr_q  <= mem_addr_d;
            wdata_q     <= wdata_d;
            beats_q     <= beats_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign mem_data = mem_oe_q ? wdata_q : {DWIDTH{1'bz}};
    assign mem_wr   = mem_wr_q;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;

    assign req_if.req_ready = (state_q == IDLE);
    assign req_if.busy      = (state_q != IDLE);
    assign req_if.rsp_valid = rsp_valid_q;
    assign req_if.rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- Initiator for the single-port memory with a shared bidirectional data bus.
- Accepts burst commands on a valid/ready request port and sequences `wr`/`rd`/`addr` cycles on the memory side, driving or releasing the tri-state data bus.
- Returns read data on a response port.
- Sits between test/control logic and the memory instance.

Parameters:
- AWIDTH, 5, memory address width
- DWIDTH, 8, memory data width
- LWIDTH, 4, burst length field width; beats per burst = req_len+1 (1..2^LWIDTH)

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when req_valid&&req_ready at rising clk
- req_write  in  1  1=write burst, 0=read burst
- req_desc  in  1  1=address decrements per beat, 0=increments
- req_addr  in  AWIDTH  first beat address
- req_wdata  in  DWIDTH  first beat write data; beat k writes req_wdata+k mod 2^DWIDTH
- req_len  in  LWIDTH  beats minus one
- rsp_valid  out  1  one-cycle pulse per read beat
- rsp_rdata  out  DWIDTH  read data, valid with rsp_valid
- busy  out  1  high whenever state != IDLE
- mem_wr  out  1  memory write strobe
- mem_rd  out  1  memory read strobe
- mem_addr  out  AWIDTH  memory address
- mem_data  inout  DWIDTH  shared data bus; driven only in WRITE, else high-Z

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; mem_wr=0, mem_rd=0, mem_addr=0, bus high-Z.
  - rsp_valid=0, rsp_rdata=0, busy=0.
  - req_ready=1 once rst_n is high.
  - Reset mid-burst aborts it immediately; no further strobes; bus released combinationally.
- Control signals: all memory-side outputs and the output enable are registered. req_ready = (state==IDLE), combinational from state.
- States: IDLE, WRITE, RD_ADDR, RD_CAP, TURN.
- IDLE:
  - On accept, latch addr, wdata, len, desc.
  - Go to WRITE if req_write, else RD_ADDR.
- WRITE:
  - One clock per beat: mem_wr=1, mem_addr=cur_addr, bus driven with cur_data.
  - Memory samples on the rising edge ending the cycle.
  - After the last beat: mem_wr=0, bus released, go to IDLE.
  - A new command is accepted no earlier than the cycle after the last beat.
- RD_ADDR, then RD_CAP: two clocks per beat, with mem_rd=1 and mem_addr stable across both.
  - The bus is sampled at the rising edge ending RD_CAP into rsp_rdata, with rsp_valid=1 for the following cycle.
  - Read latency: command accept to rsp_valid = 3 cycles for the first beat, then one beat every 2 cycles.
- After the last read beat: mem_rd=0, one TURN cycle (bus released, no strobes), then IDLE.
  - TURN prevents bus contention with the memory's read driver.
- Address arithmetic: cur_addr +/- 1 modulo 2^AWIDTH per beat; wrap 31->0 ascending and 0->31 descending, silently.
- Data arithmetic: cur_data +1 modulo 2^DWIDTH per beat.
- Mutual exclusion: mem_wr and mem_rd are never high in the same cycle. The bus is never driven while mem_rd=1 or during TURN.
- Ignored inputs: req_valid while busy is ignored, with no latching. Request fields must be stable only in the accept cycle.
- Length boundaries: req_len=0 gives one beat; req_len=2^LWIDTH-1 gives 16 beats.

Test Plan:
- Single write then read: write addr=0 data=FF, then read addr=0 -> one mem_wr cycle with bus=FF; read gives rsp_valid once with rsp_rdata=FF, 3 cycles after accept.
- Write/read extreme address: write addr=31 data=00, read addr=31 -> rsp_rdata=00; bus high-Z throughout the read and during the TURN cycle.
- Descending wrap burst: write req_addr=1, req_desc=1, req_wdata=00, req_len=3 -> mem_addr 1,0,31,30 with data 00,01,02,03.
  - Read back the same burst -> 4 rsp_valid pulses, 2 cycles apart, data 00..03.
- Full-length ascending fill: write addr=0, wdata=F8, len=15 -> data wraps F8..FF,00..07.
  - Read back with len=15 -> matches; mem_wr/mem_rd never both 1; req_ready low for the whole burst.
- Back-to-back and ignored requests:
  - req_valid held high across a read followed by a write -> write strobe begins no earlier than 2 cycles after the last mem_rd, and the bus is never driven while mem_rd=1.
  - req_valid pulsed while busy -> no effect.
- Reset mid-burst: assert rst_n=0 during beat 2 of a 4-beat write -> mem_wr=0, bus Z, busy=0 immediately.
  - After release, req_ready=1 and a new read of addr 0 returns the data written before the reset.
